uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one byte-wide UART transmitter among N_REQ requesters such as status, debug and sensor sources.
- Arbitration is round-robin, granted per packet. The grant is held from the first byte through the byte flagged last.
- Sits between the requesters and the UART TX byte interface (valid/ready). Bit timing and framing stay in the UART.
- An idle-requester timeout releases the grant so a stalled source cannot lock the line.

Parameters:
N_REQ, 4, number of requesters (2..8).
ID_W, 2, width of grant id; must equal clog2(N_REQ).
TIMEOUT_CYC, 50000, iClk cycles a granted requester may hold valid low before forced release (1 ms at 50 MHz); 0 disables the timeout.

Ports:
iClk  in  1  system clock, 50 MHz.
iRst  in  1  synchronous, active-high reset.
iReq_valid  in  N_REQ  per-requester byte valid.
iReq_data  in  8*N_REQ  per-requester byte; requester k uses bits [8k+7:8k].
iReq_last  in  N_REQ  byte is the final byte of the packet; qualified by valid.
oReq_ready  out  N_REQ  byte accepted from requester k.
oTx_valid  out  1  byte offered to UART TX.
oTx_data  out  8  byte to UART TX.
iTx_ready  in  1  UART TX accepts a byte this cycle.
oGrant  out  N_REQ  one-hot current owner; all zero when idle.
oGrant_id  out  ID_W  binary index of owner; holds last owner when idle.
oBusy  out  1  a packet is in progress.
oTimeout  out  1  one-cycle pulse on forced release.

Behaviour:
- Single clock domain, iClk.
- iRst is synchronous, active-high. All state updates on rising iClk.
- Reset values: state IDLE, oGrant 0, oGrant_id 0, oBusy 0, oTimeout 0, rr pointer N_REQ-1 (requester 0 wins first), timeout counter 0.
- Combinational outputs: oTx_valid 0, oReq_ready 0 in reset and IDLE.

IDLE:
- If any iReq_valid is set, pick the first set bit searching upward from pointer+1 (wrapping).
- Register oGrant and oGrant_id, set oBusy, go to SEND (TAG if the feature is enabled).
- No byte moves in the arbitration cycle. Grant-to-first-byte latency is 1 cycle.

SEND (granted requester g):
- Combinational pass-through: oTx_valid = iReq_valid[g], oTx_data = byte g, oReq_ready[g] = iTx_ready. oReq_ready for all other requesters is 0.
- A transfer is valid && ready. A transfer with iReq_last[g] = 1 ends the packet: next state IDLE, pointer <= g, oGrant cleared.
- Timeout counter: increments each SEND cycle with iReq_valid[g] = 0. It clears on any cycle with iReq_valid[g] = 1. UART backpressure does not count toward the timeout.
- When the counter reaches TIMEOUT_CYC-1 with valid still low: pulse oTimeout, pointer <= g, return to IDLE. The partial packet is abandoned.
- Requesters deasserting valid mid-packet is legal. Valid rising again before the timeout continues the packet.

Boundary cases:
- Single-byte packet (last on first byte) is legal.
- All requesters valid: strict rotation 0,1,2,3,0...
- Losing requesters must hold their data stable.
- iRst mid-packet: immediate return to reset values; the UART may see a truncated packet.
- TIMEOUT_CYC = 0: counter never fires.
- Re-request by the same owner right after its last byte is granted only if no other requester is valid.

Optional Feature:
Macro: UART_ARB_TAG_EN.
- Defined: a TAG state is inserted after arbitration.
  - oTx_valid = 1, oTx_data = 8'h30 + oGrant_id (ASCII '0'+id), all oReq_ready 0.
  - The tag transfers on iTx_ready, then the block enters SEND.
  - The timeout counter is held at 0 in TAG.
- Undefined: no TAG state. The byte stream is purely the requesters' bytes.

Decomposition:
- Package uart_pkg holds:
  - SYSCLK 50000000, BAUD_RATE 115200
  - state encoding IDLE/TAG/SEND (2 bits)
  - TAG_BASE 8'h30
  - default TIMEOUT_CYC
- One sub-module, rr_arbiter: purely combinational. Inputs: request vector and pointer. Outputs: one-hot grant, grant index, any_req.
- The top module holds the FSM, timeout counter and pointer register.

Test Plan:
- Req0 sends 3-byte packet 8'h41,8'h42,8'h43 (last on 8'h43), iTx_ready=1 -> UART sees 41,42,43 on consecutive cycles; oGrant=0001 for 3 cycles; oBusy falls the cycle after 43.
- Req1 and Req2 both start 2-byte packets in the same cycle after reset -> Req1's full packet completes before Req2's first byte; no interleaving.
- All 4 requesters continuously send 1-byte packets (data = 8'h10+k) -> grant order 0,1,2,3,0,1,...; each byte appears exactly once.
- Req3 sends one byte without last, then drops valid; TIMEOUT_CYC=8 -> oTimeout pulses exactly 8 cycles after valid drops; Req0, waiting, is granted next cycle.
- iTx_ready low for 20 cycles mid-packet with iReq_valid high -> no timeout, data held, oReq_ready low; packet resumes intact.
- With UART_ARB_TAG_EN, Req2 sends 8'h55 (last) -> UART sees 8'h32 then 8'h55; iRst asserted mid-tag -> outputs return to reset values the next edge.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants and state encoding for the UART TX arbiter slice.
// The optional ID-tag byte is controlled by the UART_ARB_TAG_EN macro.
package uart_pkg;

    localparam int SYSCLK              = 50000000;
    localparam int BAUD_RATE           = 115200;
    localparam int DEFAULT_TIMEOUT_CYC = SYSCLK / 1000;  // 1 ms of iClk
    localparam logic [7:0] TAG_BASE    = 8'h30;          // ASCII '0'

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAG  = 2'd1,
        SEND = 2'd2
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side byte handshakes of the TX arbiter.
// The arbiter uses the slave modport; the requesters and UART use the master modport.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]   iReq_valid;
    logic [8*N_REQ-1:0] iReq_data;
    logic [N_REQ-1:0]   iReq_last;
    logic [N_REQ-1:0]   oReq_ready;
    logic               oTx_valid;
    logic [7:0]         oTx_data;
    logic               iTx_ready;
    logic [N_REQ-1:0]   oGrant;
    logic [ID_W-1:0]    oGrant_id;
    logic               oBusy;
    logic               oTimeout;

    modport master (
        output iReq_valid, iReq_data, iReq_last, iTx_ready,
        input  oReq_ready, oTx_valid, oTx_data, oGrant, oGrant_id, oBusy, oTimeout
    );

    modport slave (
        input  iReq_valid, iReq_data, iReq_last, iTx_ready,
        output oReq_ready, oTx_valid, oTx_data, oGrant, oGrant_id, oBusy, oTimeout
    );
endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: first set request searching upward from ptr+1.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grantId,
    output logic             anyReq
);
    int idx;

    always_comb begin
        grant   = '0;
        grantId = '0;
        anyReq  = |req;
        idx     = 0;
        // Walk from farthest to nearest so the requester closest after ptr overwrites last.
        for (int off = N_REQ; off >= 1; off--) begin
            idx = (int'(ptr) + off) % N_REQ;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grantId    = ID_W'(idx);
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one UART TX byte port, with idle timeout.
// Define UART_ARB_TAG_EN to prefix each packet with an ASCII owner-id tag byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input logic              iClk,
    input logic              iRst,
    uart_tx_arbiter_if.slave bus
);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    arb_state_e       state, stateNext;
    logic [N_REQ-1:0] grantQ, grantD;
    logic [ID_W-1:0]  idQ, idD, ptrQ, ptrD;
    logic             busyQ, busyD, toQ, toD;
    logic [CNT_W-1:0] cntQ, cntD;

    logic [N_REQ-1:0] arbGrant;
    logic [ID_W-1:0]  arbId;
    logic             arbAny;
    logic             gValid, gLast;
    logic [7:0]       gData;
    logic             txValid;
    logic [7:0]       txData;
    logic [N_REQ-1:0] readyVec;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) uRr (
        .req    (bus.iReq_valid),
        .ptr    (ptrQ),
        .grant  (arbGrant),
        .grantId(arbId),
        .anyReq (arbAny)
    );

    assign gValid = bus.iReq_valid[idQ];
    assign gLast  = bus.iReq_last[idQ];
    assign gData  = bus.iReq_data[{idQ, 3'b000} +: 8];

    always_ff @(posedge iClk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (iRst) begin
            state  <= IDLE;
            grantQ <= '0;
            idQ    <= '0;
            ptrQ   <= ID_W'(N_REQ - 1);
            busyQ  <= 1'b0;
            toQ    <= 1'b0;
            cntQ   <= '0;
        end else begin
            state  <= stateNext;
            grantQ <= grantD;
            idQ    <= idD;
            ptrQ   <= ptrD;
            busyQ  <= busyD;
            toQ    <= toD;
            cntQ   <= cntD;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        stateNext = state;
        grantD    = grantQ;
        idD       = idQ;
        ptrD      = ptrQ;
        busyD     = busyQ;
        toD       = 1'b0;
        cntD      = cntQ;
        txValid   = 1'b0;
        txData    = '0;
        readyVec  = '0;

        case (state)
            IDLE: begin
                cntD = '0;
                if (arbAny) begin
                    grantD = arbGrant;
                    idD    = arbId;
                    busyD  = 1'b1;
`ifdef UART_ARB_TAG_EN
                    stateNext = TAG;
`else
                    stateNext = SEND;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            TAG: begin
                txValid = 1'b1;
                txData  = TAG_BASE + 8'(idQ);
                cntD    = '0;
                if (bus.iTx_ready) stateNext = SEND;
            end
`endif
            SEND: begin
                txValid       = gValid;
                txData        = gData;
                readyVec[idQ] = bus.iTx_ready;
                if (gValid) begin
                    cntD = '0;
                    if (bus.iTx_ready && gLast) begin
                        stateNext = IDLE;
                        ptrD      = idQ;
                        grantD    = '0;
                        busyD     = 1'b0;
                    end
                end else if (TIMEOUT_CYC == 0) begin
                    cntD = '0;
                end else if (cntQ == CNT_LAST) begin
                    // Owner stalled too long: abandon the partial packet and rotate past it.
                    toD       = 1'b1;
                    stateNext = IDLE;
                    ptrD      = idQ;
                    grantD    = '0;
                    busyD     = 1'b0;
                    cntD      = '0;
                end else begin
                    cntD = cntQ + 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase

        if (iRst) begin
            txValid  = 1'b0;
            readyVec = '0;
        end
    end

    assign bus.oTx_valid  = txValid;
    assign bus.oTx_data   = txData;
    assign bus.oReq_ready = readyVec;
    assign bus.oGrant     = grantQ;
    assign bus.oGrant_id  = idQ;
    assign bus.oBusy      = busyQ;
    assign bus.oTimeout   = toQ;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues drive the bus, a log
// records every byte the UART accepts; expected values are hand-derived.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic clk;
    logic iRst;
    logic rstNext;
    logic txReadyNext;

    uart_tx_arbiter_if #(.N_REQ(N), .ID_W(2)) bus ();

    uart_tx_arbiter #(.N_REQ(N), .ID_W(2), .TIMEOUT_CYC(8)) dut (
        .iClk(clk),
        .iRst(iRst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nTotal = 0;
    int nBad   = 0;

    logic [8:0] srcMem [N][16];
    int         srcHead [N];
    int         srcTail [N];
    logic [N-1:0] popPend;
    logic [7:0] logData [$];
    logic [1:0] logId [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTotal++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic l);
        srcMem[k][srcTail[k]] = {l, d};
        srcTail[k]++;
    endtask

    task automatic clearSrc();
        for (int k = 0; k < N; k++) begin
            srcHead[k] = 0;
            srcTail[k] = 0;
        end
        popPend = '0;
    endtask

    // One clock: apply inputs at the falling edge, settle, then record what the next rising edge will accept.
    task automatic step();
        @(negedge clk);
        iRst          = rstNext;
        bus.iTx_ready = txReadyNext;
        for (int k = 0; k < N; k++) begin
            if (popPend[k]) srcHead[k]++;
            if (srcHead[k] < srcTail[k]) begin
                bus.iReq_valid[k]      = 1'b1;
                bus.iReq_data[8*k +: 8] = srcMem[k][srcHead[k]][7:0];
                bus.iReq_last[k]       = srcMem[k][srcHead[k]][8];
            end else begin
                bus.iReq_valid[k] = 1'b0;
                bus.iReq_last[k]  = 1'b0;
            end
        end
        #1;
        popPend = bus.iReq_valid & bus.oReq_ready;
        if (bus.oTx_valid && bus.iTx_ready) begin
            logData.push_back(bus.oTx_data);
            logId.push_back(bus.oGrant_id);
        end
    endtask

    task automatic waitLog(input int n, input int budget);
        for (int i = 0; i < budget && logData.size() < n; i++) step();
        check("log_len", logData.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] expD [8];
        logic [1:0] expI [8];

        iRst           = 1'b1;
        rstNext        = 1'b1;
        txReadyNext    = 1'b1;
        bus.iTx_ready  = 1'b1;
        bus.iReq_valid = '0;
        bus.iReq_last  = '0;
        bus.iReq_data  = '0;
        clearSrc();

        // Reset state
        step();
        step();
        check("rst_grant", bus.oGrant, 0);
        check("rst_id", bus.oGrant_id, 0);
        check("rst_busy", bus.oBusy, 0);
        check("rst_timeout", bus.oTimeout, 0);
        check("rst_txvalid", bus.oTx_valid, 0);
        check("rst_ready", bus.oReq_ready, 0);
        rstNext = 1'b0;

`ifndef UART_ARB_TAG_EN
        // Req0 three-byte packet, one byte per cycle
        push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
        step();
        check("p0_arb_txvalid", bus.oTx_valid, 0);
        check("p0_arb_ready", bus.oReq_ready, 0);
        step();
        check("p0_b0_grant", bus.oGrant, 4'b0001);
        check("p0_b0_busy", bus.oBusy, 1);
        check("p0_b0_data", bus.oTx_data, 8'h41);
        check("p0_b0_ready", bus.oReq_ready, 4'b0001);
        step();
        check("p0_b1_data", bus.oTx_data, 8'h42);
        step();
        check("p0_b2_data", bus.oTx_data, 8'h43);
        check("p0_b2_grant", bus.oGrant, 4'b0001);
        step();
        check("p0_end_busy", bus.oBusy, 0);
        check("p0_end_grant", bus.oGrant, 0);
        check("p0_end_id", bus.oGrant_id, 0);

        // Req1 and Req2 start together: no interleaving
        clearSrc(); logData.delete(); logId.delete();
        push(1, 8'h61, 1'b0); push(1, 8'h62, 1'b1);
        push(2, 8'h71, 1'b0); push(2, 8'h72, 1'b1);
        waitLog(4, 20);
        expD[0] = 8'h61; expD[1] = 8'h62; expD[2] = 8'h71; expD[3] = 8'h72;
        expI[0] = 2'd1;  expI[1] = 2'd1;  expI[2] = 2'd2;  expI[3] = 2'd2;
        for (int i = 0; i < 4 && i < logData.size(); i++) begin
            check($sformatf("p12_data%0d", i), logData[i], expD[i]);
            check($sformatf("p12_id%0d", i), logId[i], expI[i]);
        end

        // All four send single-byte packets; pointer now sits at 2
        step();
        clearSrc(); logData.delete(); logId.delete();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++) push(k, 8'h10 + 8'(k), 1'b1);
        waitLog(8, 40);
        for (int i = 0; i < 8; i++) begin
            expI[i] = 2'((i + 3) % 4);
            expD[i] = 8'h10 + 8'(expI[i]);
        end
        for (int i = 0; i < 8 && i < logData.size(); i++) begin
            check($sformatf("rot_data%0d", i), logData[i], expD[i]);
            check($sformatf("rot_id%0d", i), logId[i], expI[i]);
        end

        // Req3 stalls mid-packet; Req0 waits behind it
        step();
        clearSrc(); logData.delete(); logId.delete();
        push(3, 8'h5A, 1'b0);
        push(0, 8'h77, 1'b1);
        step();
        check("to_arb_busy", bus.oBusy, 0);
        step();
        check("to_b0_grant", bus.oGrant, 4'b1000);
        check("to_b0_data", bus.oTx_data, 8'h5A);
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("to_wait%0d", i), bus.oTimeout, 0);
        end
        check("to_wait_busy", bus.oBusy, 1);
        step();
        check("to_pulse", bus.oTimeout, 1);
        check("to_pulse_grant", bus.oGrant, 0);
        check("to_pulse_txvalid", bus.oTx_valid, 0);
        step();
        check("to_after_pulse", bus.oTimeout, 0);
        check("to_next_grant", bus.oGrant, 4'b0001);
        check("to_next_data", bus.oTx_data, 8'h77);
        check("to_next_ready", bus.oReq_ready, 4'b0001);
        step();
        check("to_end_busy", bus.oBusy, 0);

        // UART backpressure for 20 cycles mid-packet
        clearSrc(); logData.delete(); logId.delete();
        push(1, 8'h81, 1'b0); push(1, 8'h82, 1'b0); push(1, 8'h83, 1'b1);
        step();
        step();
        check("bp_b0_data", bus.oTx_data, 8'h81);
        txReadyNext = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("bp_hold_data%0d", i), bus.oTx_data, 8'h82);
            check($sformatf("bp_hold_ready%0d", i), bus.oReq_ready, 0);
            check($sformatf("bp_hold_valid%0d", i), bus.oTx_valid, 1);
        end
        check("bp_no_timeout", bus.oTimeout, 0);
        check("bp_grant", bus.oGrant, 4'b0010);
        txReadyNext = 1'b1;
        step();
        check("bp_b1_ready", bus.oReq_ready, 4'b0010);
        step();
        check("bp_b2_data", bus.oTx_data, 8'h83);
        step();
        check("bp_end_busy", bus.oBusy, 0);
        check("bp_log_len", logData.size(), 3);
        if (logData.size() == 3) begin
            check("bp_log0", logData[0], 8'h81);
            check("bp_log1", logData[1], 8'h82);
            check("bp_log2", logData[2], 8'h83);
        end

        // Reset in the middle of a packet
        clearSrc();
        push(2, 8'h91, 1'b0); push(2, 8'h92, 1'b0); push(2, 8'h93, 1'b1);
        step();
        step();
        check("mr_b0_data", bus.oTx_data, 8'h91);
        check("mr_b0_grant", bus.oGrant, 4'b0100);
        rstNext = 1'b1;
        step();
        check("mr_comb_txvalid", bus.oTx_valid, 0);
        check("mr_comb_ready", bus.oReq_ready, 0);
        step();
        check("mr_grant", bus.oGrant, 0);
        check("mr_busy", bus.oBusy, 0);
        check("mr_id", bus.oGrant_id, 0);
        rstNext = 1'b0;
        clearSrc();
        step();
        check("mr_idle_busy", bus.oBusy, 0);
`else
        // Tag byte precedes the packet; pointer at reset is 3, so Req2 wins
        clearSrc(); logData.delete(); logId.delete();
        push(2, 8'h55, 1'b1);
        step();
        check("tag_arb_txvalid", bus.oTx_valid, 0);
        step();
        check("tag_txvalid", bus.oTx_valid, 1);
        check("tag_data", bus.oTx_data, 8'h32);
        check("tag_ready", bus.oReq_ready, 0);
        check("tag_grant", bus.oGrant, 4'b0100);
        step();
        check("tag_pay_data", bus.oTx_data, 8'h55);
        check("tag_pay_ready", bus.oReq_ready, 4'b0100);
        step();
        check("tag_end_busy", bus.oBusy, 0);
        check("tag_log_len", logData.size(), 2);
        if (logData.size() == 2) begin
            check("tag_log0", logData[0], 8'h32);
            check("tag_log1", logData[1], 8'h55);
        end

        // Reset while the tag is stalled
        clearSrc();
        push(2, 8'h56, 1'b1);
        txReadyNext = 1'b0;
        step();
        step();
        check("tagrst_data", bus.oTx_data, 8'h32);
        check("tagrst_busy", bus.oBusy, 1);
        rstNext = 1'b1;
        step();
        check("tagrst_comb_txvalid", bus.oTx_valid, 0);
        step();
        check("tagrst_grant", bus.oGrant, 0);
        check("tagrst_busy_after", bus.oBusy, 0);
        check("tagrst_id", bus.oGrant_id, 0);
        rstNext = 1'b0;
        txReadyNext = 1'b1;
        clearSrc();
        step();
`endif

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end
endmodule
